// File: rtl/branch_predictor_if.sv
// Fetch-lookup / resolve-update bus between the MIPS pipeline and the
// branch predictor. The pipeline side is the master, the predictor the slave.
interface branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6
) ();

  // IF-stage lookup
  logic [XLEN-1:0]  lk_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic [IDX_W-1:0] pred_idx;

  // MEM-stage resolution
  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_pred_taken;
  logic [XLEN-1:0]  upd_pred_target;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;

  modport master (
    output lk_pc,
    output upd_valid, upd_pc, upd_idx, upd_taken, upd_target,
    output upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, pred_idx,
    input  mispredict, redirect_pc
  );

  modport slave (
    input  lk_pc,
    input  upd_valid, upd_pc, upd_idx, upd_taken, upd_target,
    input  upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, pred_idx,
    output mispredict, redirect_pc
  );

endinterface

// File: rtl/branch_predictor.sv
// Branch prediction unit: PC-indexed saturating counters plus a tagged BTB,
// bimodal (MODE 0) or gshare (MODE 1) indexing. Lookup and mispredict
// detection are combinational; tables, history and perf counters update on
// the rising clock edge when a resolved branch is presented.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8,
  parameter int MODE    = 0,
  parameter int CNT_W   = 32,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic                clock,
  input  logic                reset,
  branch_predictor_if.slave   bp,
  output logic [IDX_W-1:0]    ghr_out,
  output logic [CNT_W-1:0]    perf_branches,
  output logic [CNT_W-1:0]    perf_mispredicts
);

  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = TAG_LO + TAG_W - 1;

  localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(32'd4);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_MAX >> 1;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // Saturating counter step toward the resolved outcome.
  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] ctr,
                                                input logic             taken);
    logic [CTR_W-1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_MAX) nxt = ctr + CTR_ONE;
      else                nxt = ctr;
    end else begin
      if (ctr != {CTR_W{1'b0}}) nxt = ctr - CTR_ONE;
      else                      nxt = ctr;
    end
    return nxt;
  endfunction

  // Storage (flip-flops, zero read latency)
  logic [CTR_W-1:0]   ctr_r        [ENTRIES];
  logic [ENTRIES-1:0] btb_valid_r;
  logic [TAG_W-1:0]   btb_tag_r    [ENTRIES];
  logic [XLEN-1:0]    btb_target_r [ENTRIES];
  logic [IDX_W-1:0]   ghr_r;
  logic [CNT_W-1:0]   perf_branches_r;
  logic [CNT_W-1:0]   perf_mispredicts_r;

  logic [IDX_W-1:0]   lk_idx_s;
  logic [TAG_W-1:0]   lk_tag_s;
  logic               lk_hit_s;
  logic               lk_taken_s;
  logic [TAG_W-1:0]   upd_tag_s;
  logic               mispredict_s;

  // Only the index and tag fields of the PCs matter here; the rest is folded
  // into a sink so the unused bits are accounted for.
  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^{bp.lk_pc, bp.upd_pc};

  assign upd_tag_s = bp.upd_pc[TAG_HI:TAG_LO];

  // Lookup: index (bimodal or gshare), tag compare and prediction.
  always_comb begin
    lk_idx_s       = bp.lk_pc[IDX_W+1:2];
    lk_tag_s       = bp.lk_pc[TAG_HI:TAG_LO];
    if (MODE == 32'sd1) begin
      lk_idx_s = bp.lk_pc[IDX_W+1:2] ^ ghr_r;
    end else begin
      lk_idx_s = bp.lk_pc[IDX_W+1:2];
    end
    lk_hit_s       = btb_valid_r[lk_idx_s] && (btb_tag_r[lk_idx_s] == lk_tag_s);
    // A BTB miss never predicts taken, whatever the counter says.
    lk_taken_s     = lk_hit_s && ctr_r[lk_idx_s][CTR_W-1];
    bp.pred_idx    = lk_idx_s;
    bp.pred_taken  = lk_taken_s;
    if (lk_taken_s) begin
      bp.pred_target = btb_target_r[lk_idx_s];
    end else begin
      bp.pred_target = bp.lk_pc + PC_STEP;
    end
  end

  // Resolve: flag a wrong direction or a wrong taken target, pick the fix-up PC.
  always_comb begin
    mispredict_s = bp.upd_valid &&
                   ((bp.upd_taken != bp.upd_pred_taken) ||
                    (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
    bp.mispredict = mispredict_s;
    if (bp.upd_taken) begin
      bp.redirect_pc = bp.upd_target;
    end else begin
      bp.redirect_pc = bp.upd_pc + PC_STEP;
    end
  end

  // Counter table: train the entry chosen at fetch (upd_idx, never recomputed).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= CTR_INIT;
      end
    end else if (bp.upd_valid) begin
      ctr_r[bp.upd_idx] <= ctr_next(ctr_r[bp.upd_idx], bp.upd_taken);
    end
  end

  // BTB: taken branches allocate/overwrite; not-taken leaves the entry alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btb_valid_r <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        btb_tag_r[i]    <= {TAG_W{1'b0}};
        btb_target_r[i] <= {XLEN{1'b0}};
      end
    end else if (bp.upd_valid && bp.upd_taken) begin
      btb_valid_r[bp.upd_idx]  <= 1'b1;
      btb_tag_r[bp.upd_idx]    <= upd_tag_s;
      btb_target_r[bp.upd_idx] <= bp.upd_target;
    end
  end

  // Non-speculative global history, shifted only on resolved branches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ghr_r <= {IDX_W{1'b0}};
    end else if (bp.upd_valid) begin
      ghr_r <= {ghr_r[IDX_W-2:0], bp.upd_taken};
    end
  end

  // Performance counters, saturating at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_branches_r    <= {CNT_W{1'b0}};
      perf_mispredicts_r <= {CNT_W{1'b0}};
    end else if (bp.upd_valid) begin
      if (perf_branches_r != CNT_MAX) begin
        perf_branches_r <= perf_branches_r + CNT_ONE;
      end
      if (mispredict_s && (perf_mispredicts_r != CNT_MAX)) begin
        perf_mispredicts_r <= perf_mispredicts_r + CNT_ONE;
      end
    end
  end

  assign ghr_out          = ghr_r;
  assign perf_branches    = perf_branches_r;
  assign perf_mispredicts = perf_mispredicts_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a bimodal 64-entry instance and a
// gshare 16-entry instance. Expected values are queued when stimulus is
// driven and popped when the outputs are sampled.
module tb_branch_predictor;

  logic clock;
  logic reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  branch_predictor_if #(.XLEN(32), .IDX_W(6)) bp0 ();
  branch_predictor_if #(.XLEN(32), .IDX_W(4)) bp1 ();

  logic [5:0]  ghr0;
  logic [31:0] pb0, pm0;
  logic [3:0]  ghr1;
  logic [31:0] pb1, pm1;

  branch_predictor #(.XLEN(32), .ENTRIES(64), .CTR_W(2), .TAG_W(8), .MODE(0), .CNT_W(32)) dut0 (
    .clock(clock), .reset(reset), .bp(bp0),
    .ghr_out(ghr0), .perf_branches(pb0), .perf_mispredicts(pm0)
  );

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CTR_W(2), .TAG_W(8), .MODE(1), .CNT_W(32)) dut1 (
    .clock(clock), .reset(reset), .bp(bp1),
    .ghr_out(ghr1), .perf_branches(pb1), .perf_mispredicts(pm1)
  );

  logic [31:0] sb_q [$];
  logic [31:0] e;
  int          n_cmp;
  int          n_fail;
  int          exp_br0;
  int          exp_mis0;
  logic [5:0]  exp_ghr0;

  task automatic idle0;
    bp0.upd_valid = 1'b0; bp0.upd_pc = 32'd0; bp0.upd_idx = 6'd0; bp0.upd_taken = 1'b0;
    bp0.upd_target = 32'd0; bp0.upd_pred_taken = 1'b0; bp0.upd_pred_target = 32'd0;
  endtask

  task automatic idle1;
    bp1.upd_valid = 1'b0; bp1.upd_pc = 32'd0; bp1.upd_idx = 4'd0; bp1.upd_taken = 1'b0;
    bp1.upd_target = 32'd0; bp1.upd_pred_taken = 1'b0; bp1.upd_pred_target = 32'd0;
  endtask

  task automatic drive_upd0(input logic [31:0] pc, input logic [5:0] idx, input logic taken,
                            input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    bp0.upd_valid = 1'b1; bp0.upd_pc = pc; bp0.upd_idx = idx; bp0.upd_taken = taken;
    bp0.upd_target = tgt; bp0.upd_pred_taken = ptaken; bp0.upd_pred_target = ptgt;
    exp_br0  = exp_br0 + 1;
    exp_ghr0 = {exp_ghr0[4:0], taken};
  endtask

  task automatic drive_upd1(input logic [31:0] pc, input logic [3:0] idx, input logic taken,
                            input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    bp1.upd_valid = 1'b1; bp1.upd_pc = pc; bp1.upd_idx = idx; bp1.upd_taken = taken;
    bp1.upd_target = tgt; bp1.upd_pred_taken = ptaken; bp1.upd_pred_target = ptgt;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle0; idle1;
    bp0.lk_pc = 32'h0000_0040; bp1.lk_pc = 32'h0000_0040;
    bp0.upd_pc = 32'hFFFF_FFFC;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    sb_q.push_back(32'd0); sb_q.push_back(32'h44); sb_q.push_back(32'h10); sb_q.push_back(32'd0);
    sb_q.push_back(32'd0); sb_q.push_back(32'd0); sb_q.push_back(32'd0); sb_q.push_back(32'd0);
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_taken !== e[0]) begin n_fail++; $display("FAIL reset_pred_taken: got %0h expected %0h", bp0.pred_taken, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_target !== e) begin n_fail++; $display("FAIL reset_pred_target: got %0h expected %0h", bp0.pred_target, e); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_idx !== e[5:0]) begin n_fail++; $display("FAIL reset_pred_idx: got %0h expected %0h", bp0.pred_idx, e[5:0]); end
    e = sb_q.pop_front(); n_cmp++; if (ghr0 !== e[5:0]) begin n_fail++; $display("FAIL reset_ghr: got %0h expected %0h", ghr0, e[5:0]); end
    e = sb_q.pop_front(); n_cmp++; if (pb0 !== e) begin n_fail++; $display("FAIL reset_perf_branches: got %0h expected %0h", pb0, e); end
    e = sb_q.pop_front(); n_cmp++; if (pm0 !== e) begin n_fail++; $display("FAIL reset_perf_mispredicts: got %0h expected %0h", pm0, e); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.mispredict !== e[0]) begin n_fail++; $display("FAIL reset_mispredict: got %0h expected %0h", bp0.mispredict, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.redirect_pc !== e) begin n_fail++; $display("FAIL reset_redirect_wrap: got %0h expected %0h", bp0.redirect_pc, e); end
    bp0.lk_pc = 32'hFFFF_FFFC;
    #1;
    sb_q.push_back(32'd0);
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_target !== e) begin n_fail++; $display("FAIL lookup_target_wrap: got %0h expected %0h", bp0.pred_target, e); end
  endtask

  task automatic test_train;
    @(negedge clock);
    drive_upd0(32'h40, 6'h10, 1'b1, 32'h100, 1'b0, 32'h44);
    bp0.lk_pc = 32'h40;
    exp_mis0 = exp_mis0 + 1;
    #1;
    sb_q.push_back(32'd1); sb_q.push_back(32'h100); sb_q.push_back(32'd0);
    e = sb_q.pop_front(); n_cmp++; if (bp0.mispredict !== e[0]) begin n_fail++; $display("FAIL train_mispredict: got %0h expected %0h", bp0.mispredict, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.redirect_pc !== e) begin n_fail++; $display("FAIL train_redirect: got %0h expected %0h", bp0.redirect_pc, e); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_taken !== e[0]) begin n_fail++; $display("FAIL train_same_cycle_pred: got %0h expected %0h", bp0.pred_taken, e[0]); end
    @(negedge clock);
    idle0;
    #1;
    sb_q.push_back(32'd1); sb_q.push_back(32'h100); sb_q.push_back(exp_br0); sb_q.push_back(exp_mis0);
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_taken !== e[0]) begin n_fail++; $display("FAIL train_pred_taken: got %0h expected %0h", bp0.pred_taken, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_target !== e) begin n_fail++; $display("FAIL train_pred_target: got %0h expected %0h", bp0.pred_target, e); end
    e = sb_q.pop_front(); n_cmp++; if (pb0 !== e) begin n_fail++; $display("FAIL train_perf_branches: got %0h expected %0h", pb0, e); end
    e = sb_q.pop_front(); n_cmp++; if (pm0 !== e) begin n_fail++; $display("FAIL train_perf_mispredicts: got %0h expected %0h", pm0, e); end
  endtask

  task automatic test_saturation;
    logic [2:0] nt_pred;
    logic [2:0] nt_after;
    nt_pred  = 3'b011;
    nt_after = 3'b001;
    bp0.lk_pc = 32'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      drive_upd0(32'h40, 6'h10, 1'b1, 32'h100, 1'b1, 32'h100);
      #1;
      sb_q.push_back(32'd0);
      e = sb_q.pop_front(); n_cmp++; if (bp0.mispredict !== e[0]) begin n_fail++; $display("FAIL sat_taken_mispredict[%0d]: got %0h expected %0h", i, bp0.mispredict, e[0]); end
      @(negedge clock);
      idle0;
      #1;
      sb_q.push_back(32'd1);
      e = sb_q.pop_front(); n_cmp++; if (bp0.pred_taken !== e[0]) begin n_fail++; $display("FAIL sat_taken_pred[%0d]: got %0h expected %0h", i, bp0.pred_taken, e[0]); end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive_upd0(32'h40, 6'h10, 1'b0, 32'h0, nt_pred[i], nt_pred[i] ? 32'h100 : 32'h44);
      exp_mis0 = exp_mis0 + int'(nt_pred[i]);
      #1;
      sb_q.push_back({31'd0, nt_pred[i]}); sb_q.push_back(32'h44);
      e = sb_q.pop_front(); n_cmp++; if (bp0.mispredict !== e[0]) begin n_fail++; $display("FAIL sat_nt_mispredict[%0d]: got %0h expected %0h", i, bp0.mispredict, e[0]); end
      e = sb_q.pop_front(); n_cmp++; if (bp0.redirect_pc !== e) begin n_fail++; $display("FAIL sat_nt_redirect[%0d]: got %0h expected %0h", i, bp0.redirect_pc, e); end
      @(negedge clock);
      idle0;
      #1;
      sb_q.push_back({31'd0, nt_after[i]}); sb_q.push_back(nt_after[i] ? 32'h100 : 32'h44);
      e = sb_q.pop_front(); n_cmp++; if (bp0.pred_taken !== e[0]) begin n_fail++; $display("FAIL sat_nt_pred[%0d]: got %0h expected %0h", i, bp0.pred_taken, e[0]); end
      e = sb_q.pop_front(); n_cmp++; if (bp0.pred_target !== e) begin n_fail++; $display("FAIL sat_nt_target[%0d]: got %0h expected %0h", i, bp0.pred_target, e); end
    end
    sb_q.push_back(exp_br0); sb_q.push_back(exp_mis0);
    e = sb_q.pop_front(); n_cmp++; if (pb0 !== e) begin n_fail++; $display("FAIL sat_perf_branches: got %0h expected %0h", pb0, e); end
    e = sb_q.pop_front(); n_cmp++; if (pm0 !== e) begin n_fail++; $display("FAIL sat_perf_mispredicts: got %0h expected %0h", pm0, e); end
  endtask

  task automatic test_alias;
    logic [1:0] after;
    after = 2'b10;
    bp0.lk_pc = 32'h40;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      drive_upd0(32'h40, 6'h10, 1'b1, 32'h100, 1'b0, 32'h44);
      exp_mis0 = exp_mis0 + 1;
      @(negedge clock);
      idle0;
      #1;
      sb_q.push_back({31'd0, after[i]});
      e = sb_q.pop_front(); n_cmp++; if (bp0.pred_taken !== e[0]) begin n_fail++; $display("FAIL alias_retrain_pred[%0d]: got %0h expected %0h", i, bp0.pred_taken, e[0]); end
    end
    bp0.lk_pc = 32'h1040;
    #1;
    sb_q.push_back(32'd0); sb_q.push_back(32'h1044); sb_q.push_back(32'h10);
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_taken !== e[0]) begin n_fail++; $display("FAIL alias_pred_taken: got %0h expected %0h", bp0.pred_taken, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_target !== e) begin n_fail++; $display("FAIL alias_pred_target: got %0h expected %0h", bp0.pred_target, e); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_idx !== e[5:0]) begin n_fail++; $display("FAIL alias_pred_idx: got %0h expected %0h", bp0.pred_idx, e[5:0]); end
  endtask

  task automatic test_target_mismatch;
    @(negedge clock);
    drive_upd0(32'h40, 6'h10, 1'b1, 32'h200, 1'b1, 32'h100);
    exp_mis0 = exp_mis0 + 1;
    #1;
    sb_q.push_back(32'd1); sb_q.push_back(32'h200);
    e = sb_q.pop_front(); n_cmp++; if (bp0.mispredict !== e[0]) begin n_fail++; $display("FAIL tgt_mispredict: got %0h expected %0h", bp0.mispredict, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.redirect_pc !== e) begin n_fail++; $display("FAIL tgt_redirect: got %0h expected %0h", bp0.redirect_pc, e); end
    @(negedge clock);
    idle0;
    bp0.lk_pc = 32'h40;
    #1;
    sb_q.push_back(32'd1); sb_q.push_back(32'h200);
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_taken !== e[0]) begin n_fail++; $display("FAIL tgt_pred_taken: got %0h expected %0h", bp0.pred_taken, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_target !== e) begin n_fail++; $display("FAIL tgt_pred_target: got %0h expected %0h", bp0.pred_target, e); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pc_a   [3] = '{32'h40, 32'h80, 32'h80};
    logic [5:0]  idx_a  [3] = '{6'h10, 6'h20, 6'h20};
    logic [2:0]  tk_a       = 3'b110;
    logic [31:0] tgt_a  [3] = '{32'h0, 32'h400, 32'h400};
    logic [2:0]  pt_a       = 3'b001;
    logic [31:0] ptgt_a [3] = '{32'h200, 32'h84, 32'h84};
    logic [31:0] rdr_a  [3] = '{32'h44, 32'h400, 32'h400};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive_upd0(pc_a[i], idx_a[i], tk_a[i], tgt_a[i], pt_a[i], ptgt_a[i]);
      exp_mis0 = exp_mis0 + 1;
      #1;
      sb_q.push_back(32'd1); sb_q.push_back(rdr_a[i]);
      e = sb_q.pop_front(); n_cmp++; if (bp0.mispredict !== e[0]) begin n_fail++; $display("FAIL b2b_mispredict[%0d]: got %0h expected %0h", i, bp0.mispredict, e[0]); end
      e = sb_q.pop_front(); n_cmp++; if (bp0.redirect_pc !== e) begin n_fail++; $display("FAIL b2b_redirect[%0d]: got %0h expected %0h", i, bp0.redirect_pc, e); end
    end
    @(negedge clock);
    idle0;
    bp0.lk_pc = 32'h40;
    #1;
    sb_q.push_back(32'd1); sb_q.push_back(32'h200);
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_taken !== e[0]) begin n_fail++; $display("FAIL b2b_nt_keeps_entry: got %0h expected %0h", bp0.pred_taken, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_target !== e) begin n_fail++; $display("FAIL b2b_nt_target: got %0h expected %0h", bp0.pred_target, e); end
    bp0.lk_pc = 32'h80;
    #1;
    sb_q.push_back(32'h20); sb_q.push_back(32'd1); sb_q.push_back(32'h400);
    sb_q.push_back({26'd0, exp_ghr0}); sb_q.push_back(exp_br0); sb_q.push_back(exp_mis0);
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_idx !== e[5:0]) begin n_fail++; $display("FAIL b2b_idx: got %0h expected %0h", bp0.pred_idx, e[5:0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_taken !== e[0]) begin n_fail++; $display("FAIL b2b_pred_taken: got %0h expected %0h", bp0.pred_taken, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp0.pred_target !== e) begin n_fail++; $display("FAIL b2b_pred_target: got %0h expected %0h", bp0.pred_target, e); end
    e = sb_q.pop_front(); n_cmp++; if (ghr0 !== e[5:0]) begin n_fail++; $display("FAIL b2b_ghr: got %0h expected %0h", ghr0, e[5:0]); end
    e = sb_q.pop_front(); n_cmp++; if (pb0 !== e) begin n_fail++; $display("FAIL b2b_perf_branches: got %0h expected %0h", pb0, e); end
    e = sb_q.pop_front(); n_cmp++; if (pm0 !== e) begin n_fail++; $display("FAIL b2b_perf_mispredicts: got %0h expected %0h", pm0, e); end
  endtask

  task automatic test_gshare;
    logic [2:0] tk;
    logic [2:0] misp;
    logic [3:0] ghr_exp [3] = '{4'h1, 4'h2, 4'h5};
    tk   = 3'b101;
    misp = 3'b101;
    bp1.lk_pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive_upd1(32'h40, 4'h5, tk[i], 32'h300, 1'b0, 32'h44);
      #1;
      sb_q.push_back({31'd0, misp[i]});
      e = sb_q.pop_front(); n_cmp++; if (bp1.mispredict !== e[0]) begin n_fail++; $display("FAIL gs_mispredict[%0d]: got %0h expected %0h", i, bp1.mispredict, e[0]); end
      @(negedge clock);
      idle1;
      #1;
      sb_q.push_back({28'd0, ghr_exp[i]});
      e = sb_q.pop_front(); n_cmp++; if (ghr1 !== e[3:0]) begin n_fail++; $display("FAIL gs_ghr[%0d]: got %0h expected %0h", i, ghr1, e[3:0]); end
    end
    sb_q.push_back(32'h5); sb_q.push_back(32'd1); sb_q.push_back(32'h300);
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_idx !== e[3:0]) begin n_fail++; $display("FAIL gs_pred_idx: got %0h expected %0h", bp1.pred_idx, e[3:0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_taken !== e[0]) begin n_fail++; $display("FAIL gs_pred_taken: got %0h expected %0h", bp1.pred_taken, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_target !== e) begin n_fail++; $display("FAIL gs_pred_target: got %0h expected %0h", bp1.pred_target, e); end
    // Same-cycle lookup and not-taken update of index 5: lookup sees old counter.
    @(negedge clock);
    drive_upd1(32'h40, 4'h5, 1'b0, 32'h0, 1'b1, 32'h300);
    #1;
    sb_q.push_back(32'd1); sb_q.push_back(32'h5); sb_q.push_back(32'd1);
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_taken !== e[0]) begin n_fail++; $display("FAIL gs_same_cycle_pred: got %0h expected %0h", bp1.pred_taken, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_idx !== e[3:0]) begin n_fail++; $display("FAIL gs_same_cycle_idx: got %0h expected %0h", bp1.pred_idx, e[3:0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.mispredict !== e[0]) begin n_fail++; $display("FAIL gs_same_cycle_mispredict: got %0h expected %0h", bp1.mispredict, e[0]); end
    @(negedge clock);
    idle1;
    bp1.lk_pc = 32'h7C;
    #1;
    sb_q.push_back(32'hA); sb_q.push_back(32'h5); sb_q.push_back(32'd0); sb_q.push_back(32'h80);
    sb_q.push_back(32'd4); sb_q.push_back(32'd3);
    e = sb_q.pop_front(); n_cmp++; if (ghr1 !== e[3:0]) begin n_fail++; $display("FAIL gs_after_ghr: got %0h expected %0h", ghr1, e[3:0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_idx !== e[3:0]) begin n_fail++; $display("FAIL gs_after_idx: got %0h expected %0h", bp1.pred_idx, e[3:0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_taken !== e[0]) begin n_fail++; $display("FAIL gs_after_pred: got %0h expected %0h", bp1.pred_taken, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_target !== e) begin n_fail++; $display("FAIL gs_after_target: got %0h expected %0h", bp1.pred_target, e); end
    e = sb_q.pop_front(); n_cmp++; if (pb1 !== e) begin n_fail++; $display("FAIL gs_perf_branches: got %0h expected %0h", pb1, e); end
    e = sb_q.pop_front(); n_cmp++; if (pm1 !== e) begin n_fail++; $display("FAIL gs_perf_mispredicts: got %0h expected %0h", pm1, e); end
  endtask

  task automatic test_reset_mid_update;
    @(negedge clock);
    drive_upd1(32'h40, 4'h5, 1'b1, 32'h300, 1'b0, 32'h44);
    bp1.lk_pc = 32'h54;
    #2;
    reset = 1'b0;
    #1;
    sb_q.push_back(32'd0); sb_q.push_back(32'd0); sb_q.push_back(32'd0); sb_q.push_back(32'd0); sb_q.push_back(32'h5);
    e = sb_q.pop_front(); n_cmp++; if (ghr1 !== e[3:0]) begin n_fail++; $display("FAIL rst_mid_ghr: got %0h expected %0h", ghr1, e[3:0]); end
    e = sb_q.pop_front(); n_cmp++; if (pb1 !== e) begin n_fail++; $display("FAIL rst_mid_perf_branches: got %0h expected %0h", pb1, e); end
    e = sb_q.pop_front(); n_cmp++; if (pm1 !== e) begin n_fail++; $display("FAIL rst_mid_perf_mispredicts: got %0h expected %0h", pm1, e); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_taken !== e[0]) begin n_fail++; $display("FAIL rst_mid_pred_taken: got %0h expected %0h", bp1.pred_taken, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_idx !== e[3:0]) begin n_fail++; $display("FAIL rst_mid_pred_idx: got %0h expected %0h", bp1.pred_idx, e[3:0]); end
    @(negedge clock);
    idle1;
    #1;
    reset = 1'b1;
    #1;
    sb_q.push_back(32'd0); sb_q.push_back(32'd0); sb_q.push_back(32'd0);
    e = sb_q.pop_front(); n_cmp++; if (ghr1 !== e[3:0]) begin n_fail++; $display("FAIL rst_post_ghr: got %0h expected %0h", ghr1, e[3:0]); end
    e = sb_q.pop_front(); n_cmp++; if (pb1 !== e) begin n_fail++; $display("FAIL rst_post_perf_branches: got %0h expected %0h", pb1, e); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_taken !== e[0]) begin n_fail++; $display("FAIL rst_post_write_discarded: got %0h expected %0h", bp1.pred_taken, e[0]); end
    // One taken update from weakly-not-taken must flip the prediction.
    @(negedge clock);
    drive_upd1(32'h40, 4'h5, 1'b1, 32'h300, 1'b0, 32'h44);
    @(negedge clock);
    idle1;
    bp1.lk_pc = 32'h50;
    #1;
    sb_q.push_back(32'h1); sb_q.push_back(32'h5); sb_q.push_back(32'd1); sb_q.push_back(32'h300); sb_q.push_back(32'd1);
    e = sb_q.pop_front(); n_cmp++; if (ghr1 !== e[3:0]) begin n_fail++; $display("FAIL rst_retrain_ghr: got %0h expected %0h", ghr1, e[3:0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_idx !== e[3:0]) begin n_fail++; $display("FAIL rst_retrain_idx: got %0h expected %0h", bp1.pred_idx, e[3:0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_taken !== e[0]) begin n_fail++; $display("FAIL rst_retrain_pred: got %0h expected %0h", bp1.pred_taken, e[0]); end
    e = sb_q.pop_front(); n_cmp++; if (bp1.pred_target !== e) begin n_fail++; $display("FAIL rst_retrain_target: got %0h expected %0h", bp1.pred_target, e); end
    e = sb_q.pop_front(); n_cmp++; if (pb1 !== e) begin n_fail++; $display("FAIL rst_retrain_perf: got %0h expected %0h", pb1, e); end
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    exp_br0  = 0;
    exp_mis0 = 0;
    exp_ghr0 = 6'd0;
    test_reset;
    test_train;
    test_saturation;
    test_alias;
    test_target_mismatch;
    test_back_to_back;
    test_gshare;
    test_reset_mid_update;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
